// File: rtl/n44_rx_framer_if.sv
// Beat-in / codeword-out bus of the n44 receive framer.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1; once valid is raised, the source holds its payload until that transfer.
interface n44_rx_framer_if #(
  parameter int N    = 44,
  parameter int IN_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic            in_sof;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [0:N-1]    out_cw;
  logic            sync_err;
  logic [15:0]     cw_count;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_cw, sync_err, cw_count
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_cw, sync_err, cw_count
  );
endinterface

// File: rtl/n44_rx_framer.sv
// Packs IN_W-bit channel beats into N-bit codewords c[0:N-1] for the n44k32b5 decoder.
// Storage is an accumulator plus an output register, so beats keep flowing while a codeword waits.
module n44_rx_framer #(
  parameter int N    = 44,
  parameter int IN_W = 4
) (
  input logic             clk,
  input logic             rst,
  n44_rx_framer_if.slave  bus
);
  localparam int BEATS = N / IN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [0:N-1]  acc_q, acc_d;
  logic          acc_full_q, acc_full_d;
  logic [0:N-1]  out_cw_q, out_cw_d;
  logic          out_valid_q, out_valid_d;
  logic          sync_err_q, sync_err_d;
  logic [15:0]   cw_count_q, cw_count_d;

  logic accept, mv, ready, xfer;

  // ready depends on out_ready so a full accumulator can drain and refill in the same cycle
  assign mv     = acc_full_q & (~out_valid_q | bus.out_ready);
  assign ready  = ~acc_full_q | mv;
  assign accept = bus.in_valid & ready;
  assign xfer   = out_valid_q & bus.out_ready;

  always_comb begin
    bcnt_d      = bcnt_q;
    acc_d       = acc_q;
    acc_full_d  = acc_full_q;
    out_cw_d    = out_cw_q;
    out_valid_d = out_valid_q;
    sync_err_d  = 1'b0;
    cw_count_d  = cw_count_q + 16'(xfer);

    if (mv) begin
      out_cw_d    = acc_q;
      out_valid_d = 1'b1;
      acc_full_d  = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    // in_data[IN_W-1] lands on the lowest c index of the beat's slot
    if (accept) begin
      if (bcnt_q == '0 && !bus.in_sof) begin
        sync_err_d = 1'b1;
      end else if (bcnt_q != '0 && bus.in_sof) begin
        sync_err_d          = 1'b1;
        acc_d[0 +: IN_W]    = bus.in_data;
        bcnt_d              = BW'(1);
      end else begin
        acc_d[int'(bcnt_q) * IN_W +: IN_W] = bus.in_data;
        if (bcnt_q == LAST) begin
          bcnt_d     = '0;
          acc_full_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q      <= '0;
      acc_q       <= '0;
      acc_full_q  <= 1'b0;
      out_cw_q    <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      cw_count_q  <= '0;
    end else begin
      bcnt_q      <= bcnt_d;
      acc_q       <= acc_d;
      acc_full_q  <= acc_full_d;
      out_cw_q    <= out_cw_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      cw_count_q  <= cw_count_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cw    = out_cw_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.cw_count  = cw_count_q;
endmodule

// File: tb/tb_n44_rx_framer.sv
// Bench for n44_rx_framer: directed framing scenarios plus random traffic against a codeword-level model.
module tb_n44_rx_framer;
  localparam int N     = 44;
  localparam int IN_W  = 4;
  localparam int BEATS = N / IN_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  n44_rx_framer_if #(.N(N), .IN_W(IN_W)) bus ();
  n44_rx_framer #(.N(N), .IN_W(IN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: beats of the frame in progress, completed-but-undelivered codewords with
  // the edge they completed on; a codeword is offered from the edge after completion.
  logic [IN_W-1:0] cur_q[$];
  logic [N-1:0]    exp_q[$];
  int              exp_t[$];
  int              cyc;
  int              delivered;
  logic            exp_serr;
  logic [N-1:0]    last_cw;

  task automatic model_reset();
    cur_q.delete();
    exp_q.delete();
    exp_t.delete();
    delivered = 0;
    exp_serr  = 1'b0;
  endtask

  task automatic step(input logic v, input logic s, input logic [IN_W-1:0] d,
                      input logic ordy, input logic r, output logic acc_o);
    logic         ev, er, xf, err;
    logic [N-1:0] cw;
    @(negedge clk);
    ev = (exp_q.size() > 0) && (exp_t[0] < cyc);
    check("out_valid", bus.out_valid, ev);
    if (ev) check("out_cw", bus.out_cw, exp_q[0]);
    check("sync_err", bus.sync_err, exp_serr);
    check("cw_count", bus.cw_count, 16'(delivered));
    rst           = r;
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    er = (exp_q.size() < 2) || ordy;
    check("in_ready", bus.in_ready, er);
    acc_o = v & er & ~r;
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      xf  = ordy & ev;
      err = 1'b0;
      if (xf) begin
        last_cw = bus.out_cw;
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
        delivered++;
      end
      if (acc_o) begin
        if (cur_q.size() == 0 && !s) begin
          err = 1'b1;
        end else begin
          if (s && cur_q.size() != 0) begin
            err = 1'b1;
            cur_q.delete();
          end
          cur_q.push_back(d);
          if (cur_q.size() == BEATS) begin
            cw = '0;
            foreach (cur_q[k]) cw = (cw << IN_W) | N'(cur_q[k]);
            exp_q.push_back(cw);
            exp_t.push_back(cyc);
            cur_q.delete();
          end
        end
      end
      exp_serr = err;
    end
  endtask

  task automatic send_beat(input logic s, input logic [IN_W-1:0] d, input logic ordy);
    logic a;
    int   n;
    n = 0;
    a = 1'b0;
    while (!a && n < 40) begin
      step(1'b1, s, d, ordy, 1'b0, a);
      n++;
    end
    if (!a) check("beat_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [N-1:0] cw, input logic ordy);
    for (int k = 0; k < BEATS; k++) send_beat(k == 0, cw[N-1-k*IN_W -: IN_W], ordy);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, ordy, 1'b0, a);
  endtask

  task automatic do_reset();
    logic a;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, a);
  endtask

  logic [N-1:0] cw_a, cw_b, cw_c, cw_x;
  logic         a;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    cyc           = 0;
    last_cw       = '0;
    model_reset();
    do_reset();
    do_reset();
    idle(1, 1'b1);
    check("rst_out_cw", bus.out_cw, 44'h0);

    // 1: alternating F/0 beats
    send_frame(44'hF0F0F0F0F0F, 1'b1);
    idle(4, 1'b1);
    check("t1_cw", last_cw, 44'hF0F0F0F0F0F);
    check("t1_count", bus.cw_count, 16'd1);

    // 2: back-to-back A then B
    do_reset();
    cw_a = {$urandom, $urandom};
    cw_b = {$urandom, $urandom};
    send_frame(cw_a, 1'b1);
    send_frame(cw_b, 1'b1);
    idle(4, 1'b1);
    check("t2_cw", last_cw, cw_b);
    check("t2_count", bus.cw_count, 16'd2);

    // 3: three codewords against a stalled decoder
    do_reset();
    cw_c = {$urandom, $urandom};
    send_frame(cw_a, 1'b0);
    send_frame(cw_b, 1'b0);
    step(1'b1, 1'b1, cw_c[N-1 -: IN_W], 1'b0, 1'b0, a);
    check("t3_stall", a, 1'b0);
    check("t3_held", bus.out_cw, cw_a);
    send_frame(cw_c, 1'b1);
    idle(4, 1'b1);
    check("t3_cw", last_cw, cw_c);
    check("t3_count", bus.cw_count, 16'd3);

    // 4: sof reasserted at beat 5
    do_reset();
    cw_x = {$urandom, $urandom};
    for (int k = 0; k < 5; k++) send_beat(k == 0, 4'(k + 3), 1'b1);
    send_frame(cw_x, 1'b1);
    idle(4, 1'b1);
    check("t4_cw", last_cw, cw_x);
    check("t4_count", bus.cw_count, 16'd1);

    // 5: beat without sof while idle
    do_reset();
    send_beat(1'b0, 4'hA, 1'b1);
    idle(1, 1'b1);
    send_frame(cw_a, 1'b1);
    idle(4, 1'b1);
    check("t5_cw", last_cw, cw_a);

    // 6: reset mid-frame and while out_valid=1
    do_reset();
    for (int k = 0; k < 7; k++) send_beat(k == 0, 4'(k), 1'b1);
    do_reset();
    idle(1, 1'b1);
    check("t6_rst1_cw", bus.out_cw, 44'h0);
    send_frame(cw_b, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(1, 1'b1);
    check("t6_rst2_cw", bus.out_cw, 44'h0);
    send_frame(cw_c, 1'b1);
    idle(4, 1'b1);
    check("t6_cw", last_cw, cw_c);
    check("t6_count", bus.cw_count, 16'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, s, o, r;
      v = ($urandom_range(0, 3) != 0);
      s = (cur_q.size() == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 31) == 0);
      o = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 499) == 0);
      step(v, s, 4'($urandom), o, r, a);
    end
    idle(8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
